// File: rtl/otter_intr_pkg.sv
// Shared addresses, FSM state and cause record for the OTTER interrupt controller.
package otter_intr_pkg;

    localparam logic [31:0] ENABLE_AD = 32'h1124_0000;
    localparam logic [31:0] PEND_AD   = 32'h1124_4000;
    localparam logic [31:0] CAUSE_AD  = 32'h1124_8000;
    localparam logic [31:0] ACK_AD    = 32'h1124_C000;

    typedef enum logic [1:0] {IDLE, ASSERT, WAIT_ACK} intr_state_t;

    typedef struct packed {
        logic       valid;
        logic [7:0] src_id;
    } cause_t;

    function automatic logic [31:0] cause_word(input cause_t c);
        return {c.valid, 23'b0, c.src_id};
    endfunction

endpackage

// File: rtl/intr_edge_capture.sv
// One interrupt source: optional 2-flop synchroniser (INTR_SYNC_EN) then rising-edge detect.
module intr_edge_capture (
    input  logic CLK,
    input  logic RST_N,
    input  logic irq,
    output logic rise
);

    logic s;
    logic src_q;

`ifdef INTR_SYNC_EN
    logic [1:0] sync;
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) sync <= '0;
        else        sync <= {sync[0], irq};
    end
    assign s = sync[1];
`else
    assign s = irq;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) src_q <= 1'b0;
        else        src_q <= s;
    end

    assign rise = s & ~src_q;

endmodule

// File: rtl/otter_intr_ctrl.sv
// IOBUS interrupt controller: edge-captured pending bits, enable mask, fixed-priority dispatch
// with ACK hold-off. Define INTR_SYNC_EN to synchronise IRQ_SRC before edge capture.
module otter_intr_ctrl
    import otter_intr_pkg::*;
#(
    parameter int N_SRC      = 4,
    parameter int INTR_PULSE = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [N_SRC-1:0] IRQ_SRC,
    input  logic [31:0]      IOBUS_ADDR,
    input  logic [31:0]      IOBUS_OUT,
    input  logic             IOBUS_WR,
    output logic [31:0]      IOBUS_RD,
    output logic             INTR
);

    localparam int CW = (INTR_PULSE > 1) ? $clog2(INTR_PULSE) : 1;

    logic [N_SRC-1:0] rise, enable, pend, pend_nxt, ready, w1c, sel_oh;
    logic [7:0]       sel_id;
    logic [CW-1:0]    pulse_cnt, pulse_cnt_nxt;
    logic             intr_nxt, disp;
    intr_state_t      state, state_nxt;
    cause_t           cause, cause_nxt;
    logic             en_wr, pend_wr, ack_wr;
    logic             unused_iobus;

    assign unused_iobus = ^IOBUS_OUT[31:N_SRC];

    for (genvar g = 0; g < N_SRC; g++) begin : g_cap
        intr_edge_capture u_cap (
            .CLK  (CLK),
            .RST_N(RST_N),
            .irq  (IRQ_SRC[g]),
            .rise (rise[g])
        );
    end

    assign en_wr   = IOBUS_WR && (IOBUS_ADDR == ENABLE_AD);
    assign pend_wr = IOBUS_WR && (IOBUS_ADDR == PEND_AD);
    assign ack_wr  = IOBUS_WR && (IOBUS_ADDR == ACK_AD);
    assign w1c     = pend_wr ? IOBUS_OUT[N_SRC-1:0] : '0;
    assign ready   = pend & enable;

    // Lowest index wins: scan downward so the last hit is the smallest.
    always_comb begin
        sel_id = '0;
        sel_oh = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (ready[i]) begin
                sel_id    = 8'(i);
                sel_oh    = '0;
                sel_oh[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        intr_nxt      = INTR;
        pulse_cnt_nxt = pulse_cnt;
        cause_nxt     = cause;
        disp          = 1'b0;
        case (state)
            IDLE: if (|ready) begin
                disp          = 1'b1;
                cause_nxt     = '{valid: 1'b1, src_id: sel_id};
                intr_nxt      = 1'b1;
                pulse_cnt_nxt = CW'(INTR_PULSE - 1);
                state_nxt     = ASSERT;
            end
            ASSERT: if (pulse_cnt == '0) begin
                intr_nxt  = 1'b0;
                state_nxt = WAIT_ACK;
            end else begin
                pulse_cnt_nxt = pulse_cnt - CW'(1);
            end
            // ACK retires the whole cause record so CAUSE reads back 0 while idle.
            WAIT_ACK: if (ack_wr) begin
                cause_nxt = '0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // New edges win over both W1C and the dispatch clear.
        pend_nxt = (pend & ~w1c & ~(disp ? sel_oh : '0)) | rise;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            INTR      <= 1'b0;
            pulse_cnt <= '0;
            cause     <= '0;
            pend      <= '0;
            enable    <= '0;
        end else begin
            state     <= state_nxt;
            INTR      <= intr_nxt;
            pulse_cnt <= pulse_cnt_nxt;
            cause     <= cause_nxt;
            pend      <= pend_nxt;
            if (en_wr) enable <= IOBUS_OUT[N_SRC-1:0];
        end
    end

    always_comb begin
        case (IOBUS_ADDR)
            ENABLE_AD: IOBUS_RD = {{(32-N_SRC){1'b0}}, enable};
            PEND_AD:   IOBUS_RD = {{(32-N_SRC){1'b0}}, pend};
            CAUSE_AD:  IOBUS_RD = cause_word(cause);
            default:   IOBUS_RD = '0;
        endcase
    end

endmodule

// File: tb/tb_otter_intr_ctrl.sv
// Directed + randomized bench for otter_intr_ctrl against a cycle-level behavioural model.
module tb_otter_intr_ctrl;
    import otter_intr_pkg::*;

    localparam int N = 4;
    localparam int P = 2;
`ifdef INTR_SYNC_EN
    localparam int SD = 2;
`else
    localparam int SD = 0;
`endif

    logic          CLK = 1'b0;
    logic          RST_N;
    logic [N-1:0]  IRQ_SRC;
    logic [31:0]   IOBUS_ADDR, IOBUS_OUT, IOBUS_RD;
    logic          IOBUS_WR, INTR;

    always #5 CLK = ~CLK;

    otter_intr_ctrl #(.N_SRC(N), .INTR_PULSE(P)) dut (
        .CLK(CLK), .RST_N(RST_N), .IRQ_SRC(IRQ_SRC), .IOBUS_ADDR(IOBUS_ADDR),
        .IOBUS_OUT(IOBUS_OUT), .IOBUS_WR(IOBUS_WR), .IOBUS_RD(IOBUS_RD), .INTR(INTR)
    );

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Model: in-service flag plus a count of INTR-high cycles still owed.
    logic [N-1:0] m_en, m_pend, m_prev, m_s1, m_s2;
    bit           m_busy, m_cv;
    int           m_left, m_cid;

    task automatic m_reset();
        m_en = '0; m_pend = '0; m_prev = '0; m_s1 = '0; m_s2 = '0;
        m_busy = 0; m_cv = 0; m_left = 0; m_cid = 0;
    endtask

    function automatic logic [31:0] m_rd(input logic [31:0] a);
        if (a == ENABLE_AD) return 32'(m_en);
        if (a == PEND_AD)   return 32'(m_pend);
        if (a == CAUSE_AD)  return m_cv ? (32'h8000_0000 | 32'(m_cid)) : 32'h0;
        return 32'h0;
    endfunction

    task automatic m_step(input logic [N-1:0] irq, input logic wr,
                          input logic [31:0] addr, input logic [31:0] dat);
        logic [N-1:0] r, clr, d;
        int id;
        d = dat[N-1:0];
        if (SD > 0) begin
            r = m_s2 & ~m_prev; m_prev = m_s2; m_s2 = m_s1; m_s1 = irq;
        end else begin
            r = irq & ~m_prev;  m_prev = irq;
        end
        clr = (wr && addr == PEND_AD) ? d : '0;
        id = -1;
        for (int i = N - 1; i >= 0; i--) if (m_pend[i] && m_en[i]) id = i;
        if (!m_busy && id >= 0) begin
            m_busy = 1; m_left = P; m_cv = 1; m_cid = id; clr[id] = 1'b1;
        end else if (m_busy && m_left > 0) begin
            m_left--;
        end else if (m_busy && wr && addr == ACK_AD) begin
            m_busy = 0; m_cv = 0; m_cid = 0;
        end
        m_pend = (m_pend & ~clr) | r;
        if (wr && addr == ENABLE_AD) m_en = d;
    endtask

    // One bus cycle: drive, check against model, clock, advance model.
    task automatic cyc(input logic [N-1:0] irq, input logic wr,
                       input logic [31:0] addr, input logic [31:0] dat);
        IRQ_SRC = irq; IOBUS_WR = wr; IOBUS_ADDR = addr; IOBUS_OUT = dat;
        #1;
        chk("m_intr", 32'(INTR), 32'(m_left > 0));
        chk("m_rd", IOBUS_RD, m_rd(addr));
        @(posedge CLK);
        m_step(irq, wr, addr, dat);
        #1;
    endtask

    task automatic idle(input int n, input logic [N-1:0] irq);
        for (int k = 0; k < n; k++) cyc(irq, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic peek(input logic [31:0] a, input string tag, input logic [31:0] exp);
        IOBUS_WR = 1'b0; IOBUS_ADDR = a;
        #1;
        chk(tag, IOBUS_RD, exp);
    endtask

    logic [N-1:0] cur;
    logic [31:0]  ad;

    initial begin
        RST_N = 1'b0; IRQ_SRC = '0; IOBUS_ADDR = '0; IOBUS_OUT = '0; IOBUS_WR = 1'b0;
        m_reset();
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_intr", 32'(INTR), 32'h0);
        peek(ENABLE_AD, "rst_en", 32'h0);
        peek(PEND_AD, "rst_pend", 32'h0);
        peek(CAUSE_AD, "rst_cause", 32'h0);
        @(negedge CLK); RST_N = 1'b1;

        // Single source
        cyc(4'h0, 1, ENABLE_AD, 32'h2);
        peek(ENABLE_AD, "t2_en", 32'h2);
        cyc(4'h2, 0, 0, 0); idle(SD, 4'h2);
        peek(PEND_AD, "t2_pend", 32'h2);
        chk("t2_intr_lo", 32'(INTR), 32'h0);
        cyc(4'h2, 0, 0, 0);
        peek(CAUSE_AD, "t2_cause", 32'h8000_0001);
        peek(PEND_AD, "t2_pend_clr", 32'h0);
        chk("t2_intr_hi", 32'(INTR), 32'h1);
        cyc(4'h2, 0, 0, 0);
        chk("t2_intr_hi2", 32'(INTR), 32'h1);
        cyc(4'h2, 0, 0, 0);
        chk("t2_intr_end", 32'(INTR), 32'h0);
        cyc(4'h2, 1, ACK_AD, 32'h0);
        peek(CAUSE_AD, "t2_ack", 32'h0);

        // Priority, then ACK during ASSERT ignored
        cyc(4'h2, 1, ENABLE_AD, 32'hF);
        cyc(4'h0, 0, 0, 0); idle(SD, 4'h0);
        cyc(4'h9, 0, 0, 0); idle(SD, 4'h9);
        peek(PEND_AD, "t3_pend", 32'h9);
        cyc(4'h9, 0, 0, 0);
        peek(CAUSE_AD, "t3_first", 32'h8000_0000);
        cyc(4'h9, 0, 0, 0); cyc(4'h9, 0, 0, 0);
        cyc(4'h9, 1, ACK_AD, 32'h0);
        cyc(4'h9, 0, 0, 0);
        peek(CAUSE_AD, "t3_second", 32'h8000_0003);
        chk("t3_intr", 32'(INTR), 32'h1);
        cyc(4'h9, 1, ACK_AD, 32'h0);
        peek(CAUSE_AD, "t5_ack_in_assert", 32'h8000_0003);
        cyc(4'h9, 0, 0, 0);
        cyc(4'h9, 1, ACK_AD, 32'h0);
        peek(CAUSE_AD, "t3_ack", 32'h0);

        // Mask and W1C
        cyc(4'h9, 1, ENABLE_AD, 32'h0);
        cyc(4'h0, 0, 0, 0); idle(SD, 4'h0);
        cyc(4'h4, 0, 0, 0); idle(SD, 4'h4);
        peek(PEND_AD, "t4_masked", 32'h4);
        chk("t4_intr_lo", 32'(INTR), 32'h0);
        cyc(4'h4, 1, PEND_AD, 32'h4);
        peek(PEND_AD, "t4_w1c", 32'h0);
        cyc(4'h0, 0, 0, 0); idle(SD, 4'h0);
        for (int k = 0; k <= SD; k++)
            cyc(4'h4, k == SD, (k == SD) ? PEND_AD : 32'h0, 32'h4);
        peek(PEND_AD, "t4_set_wins", 32'h4);
        cyc(4'h4, 1, ENABLE_AD, 32'h4);
        chk("t4_no_disp_yet", 32'(INTR), 32'h0);
        cyc(4'h4, 0, 0, 0);
        peek(CAUSE_AD, "t4_disp", 32'h8000_0002);

        // Hold-off during WAIT_ACK
        cyc(4'h4, 0, 0, 0); cyc(4'h4, 0, 0, 0);
        cyc(4'h4, 1, ENABLE_AD, 32'hF);
        cyc(4'h5, 0, 0, 0); idle(SD, 4'h5);
        idle(3, 4'h5);
        chk("t5_holdoff", 32'(INTR), 32'h0);
        peek(PEND_AD, "t5_pend", 32'h1);
        cyc(4'h5, 1, ACK_AD, 32'h0);
        chk("t5_ack_idle", 32'(INTR), 32'h0);
        cyc(4'h5, 0, 0, 0);
        peek(CAUSE_AD, "t5_disp", 32'h8000_0000);
        chk("t5_intr", 32'(INTR), 32'h1);

        // Randomized traffic
        cur = 4'h5;
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < N; b++) if ($urandom_range(7) == 0) cur[b] = ~cur[b];
            case ($urandom_range(5))
                0:       ad = ENABLE_AD;
                1:       ad = PEND_AD;
                2, 3:    ad = ACK_AD;
                4:       ad = CAUSE_AD;
                default: ad = $urandom;
            endcase
            cyc(cur, $urandom_range(3) == 0, ad, $urandom);
        end

        // Async reset in the middle of ASSERT
        RST_N = 1'b0; m_reset();
        @(negedge CLK); RST_N = 1'b1;
        cyc(4'h0, 1, ENABLE_AD, 32'h1);
        cyc(4'h1, 0, 0, 0); idle(SD, 4'h1);
        cyc(4'h1, 0, 0, 0);
        chk("t1_in_assert", 32'(INTR), 32'h1);
        RST_N = 1'b0; m_reset();
        #1;
        chk("t1_intr_async", 32'(INTR), 32'h0);
        peek(ENABLE_AD, "t1_en", 32'h0);
        peek(PEND_AD, "t1_pend", 32'h0);
        peek(CAUSE_AD, "t1_cause", 32'h0);
        @(negedge CLK); RST_N = 1'b1;
        idle(4, 4'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
